// File: rtl/axi_checker_pkg.sv
// Shared types for the AXI burst beat checker: error codes, tracker states, length width.
package axi_checker_pkg;

    localparam int LEN_WIDTH = 8;

    typedef enum logic [2:0] {
        ERR_NONE         = 3'd0,
        ERR_DATA_NO_ADDR = 3'd1,
        ERR_EARLY_LAST   = 3'd2,
        ERR_MISSING_LAST = 3'd3,
        ERR_OVERFLOW     = 3'd4
    } err_code_e;

    typedef enum logic [1:0] {
        TRK_IDLE     = 2'd0,
        TRK_ACTIVE   = 2'd1,
        TRK_IN_BURST = 2'd2
    } tracker_state_e;

endpackage

// File: rtl/axi_burst_len_tracker.sv
// One direction of the burst checker: length FIFO, beat counter, state, first-error capture.
// Optional stall counter under AXI_BURST_CHECKER_STALL_STATS_EN.
module axi_burst_len_tracker
    import axi_checker_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 a_valid,
    input  logic                 a_ready,
    input  logic [LEN_WIDTH-1:0] a_len,
    input  logic                 d_valid,
    input  logic                 d_ready,
    input  logic                 d_last,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] burst_count,
    output logic                 err,
    output logic [2:0]           err_code
`ifdef AXI_BURST_CHECKER_STALL_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0] stall_count
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_OCC = (PW+1)'(DEPTH);

    logic [LEN_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]        wr_ptr, rd_ptr;
    logic [PW:0]          occ, occ_nxt;
    logic [LEN_WIDTH-1:0] beat, beat_nxt, hl;
    tracker_state_e       state;
    err_code_e            new_err;
    logic push, beat_hs, empty, full, has_head, at_end, close, pop, store, ovf;

    // The FIFO is empty exactly when the tracker is idle: a nonzero beat count implies a stored head.
    always_comb begin
        push     = a_valid && a_ready;
        beat_hs  = d_valid && d_ready;
        empty    = (state == TRK_IDLE);
        full     = (occ == FULL_OCC);
        hl       = empty ? a_len : mem[rd_ptr];
        has_head = !empty || push;
        at_end   = (beat == hl);
        close    = beat_hs && has_head && (d_last || at_end);
        pop      = close && !empty;
        store    = push && !(close && empty) && (!full || pop);
        ovf      = push && full && !pop;

        new_err = ERR_NONE;
        if (beat_hs && !has_head)
            new_err = ERR_DATA_NO_ADDR;
        else if (beat_hs && d_last && !at_end)
            new_err = ERR_EARLY_LAST;
        else if (beat_hs && !d_last && at_end)
            new_err = ERR_MISSING_LAST;
        else if (ovf)
            new_err = ERR_OVERFLOW;

        beat_nxt = beat;
        if (close)
            beat_nxt = '0;
        else if (beat_hs && has_head)
            beat_nxt = beat + 1'b1;

        occ_nxt = occ + {{PW{1'b0}}, store} - {{PW{1'b0}}, pop};
    end

    always_ff @(posedge clk) begin
        if (store)
            mem[wr_ptr] <= a_len;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            occ         <= '0;
            beat        <= '0;
            state       <= TRK_IDLE;
            done        <= 1'b0;
            burst_count <= '0;
            err         <= 1'b0;
            err_code    <= ERR_NONE;
        end else begin
            if (store) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            occ  <= occ_nxt;
            beat <= beat_nxt;
            if (beat_nxt != '0)
                state <= TRK_IN_BURST;
            else if (occ_nxt != '0)
                state <= TRK_ACTIVE;
            else
                state <= TRK_IDLE;

            done <= close;
            if (close && burst_count != '1)
                burst_count <= burst_count + 1'b1;

            if (new_err != ERR_NONE && !err) begin
                err      <= 1'b1;
                err_code <= new_err;
            end
        end
    end

`ifdef AXI_BURST_CHECKER_STALL_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_count <= '0;
        else if (d_valid && !d_ready && stall_count != '1)
            stall_count <= stall_count + 1'b1;
    end
`endif

endmodule

// File: rtl/axi_burst_beat_checker.sv
// Passive AXI4 burst/beat checker: independent write (AW/W) and read (AR/R) trackers.
// Stall counter ports exist only when AXI_BURST_CHECKER_STALL_STATS_EN is defined.
module axi_burst_beat_checker
    import axi_checker_pkg::*;
#(
    parameter int LEN_FIFO_DEPTH = 4,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 aw_valid,
    input  logic                 aw_ready,
    input  logic [LEN_WIDTH-1:0] aw_len,
    input  logic                 w_valid,
    input  logic                 w_ready,
    input  logic                 w_last,
    input  logic                 ar_valid,
    input  logic                 ar_ready,
    input  logic [LEN_WIDTH-1:0] ar_len,
    input  logic                 r_valid,
    input  logic                 r_ready,
    input  logic                 r_last,
    output logic                 wr_burst_done,
    output logic                 rd_burst_done,
    output logic [CNT_WIDTH-1:0] wr_burst_count,
    output logic [CNT_WIDTH-1:0] rd_burst_count,
    output logic                 wr_err,
    output logic                 rd_err,
    output logic [2:0]           wr_err_code,
    output logic [2:0]           rd_err_code
`ifdef AXI_BURST_CHECKER_STALL_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0] wr_stall_count,
    output logic [CNT_WIDTH-1:0] rd_stall_count
`endif
);

    axi_burst_len_tracker #(.DEPTH(LEN_FIFO_DEPTH), .CNT_WIDTH(CNT_WIDTH)) u_wr (
        .clk         (clk),
        .rst         (rst),
        .a_valid     (aw_valid),
        .a_ready     (aw_ready),
        .a_len       (aw_len),
        .d_valid     (w_valid),
        .d_ready     (w_ready),
        .d_last      (w_last),
        .done        (wr_burst_done),
        .burst_count (wr_burst_count),
        .err         (wr_err),
        .err_code    (wr_err_code)
`ifdef AXI_BURST_CHECKER_STALL_STATS_EN
        ,
        .stall_count (wr_stall_count)
`endif
    );

    axi_burst_len_tracker #(.DEPTH(LEN_FIFO_DEPTH), .CNT_WIDTH(CNT_WIDTH)) u_rd (
        .clk         (clk),
        .rst         (rst),
        .a_valid     (ar_valid),
        .a_ready     (ar_ready),
        .a_len       (ar_len),
        .d_valid     (r_valid),
        .d_ready     (r_ready),
        .d_last      (r_last),
        .done        (rd_burst_done),
        .burst_count (rd_burst_count),
        .err         (rd_err),
        .err_code    (rd_err_code)
`ifdef AXI_BURST_CHECKER_STALL_STATS_EN
        ,
        .stall_count (rd_stall_count)
`endif
    );

endmodule

// File: tb/tb_axi_burst_beat_checker.sv
// Self-checking bench for axi_burst_beat_checker: write-side vector table, hand sequences,
// and a done-pulse scoreboard of expected burst counts.
module tb_axi_burst_beat_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        aw_valid = 0, aw_ready = 0, w_valid = 0, w_ready = 0, w_last = 0;
    logic        ar_valid = 0, ar_ready = 0, r_valid = 0, r_ready = 0, r_last = 0;
    logic [7:0]  aw_len = 0, ar_len = 0;
    logic        wr_burst_done, rd_burst_done, wr_err, rd_err;
    logic [31:0] wr_burst_count, rd_burst_count;
    logic [2:0]  wr_err_code, rd_err_code;
`ifdef AXI_BURST_CHECKER_STALL_STATS_EN
    logic [31:0] wr_stall_count, rd_stall_count;
`endif

    axi_burst_beat_checker dut (
        .clk(clk), .rst(rst),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_len(aw_len),
        .w_valid(w_valid), .w_ready(w_ready), .w_last(w_last),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_len(ar_len),
        .r_valid(r_valid), .r_ready(r_ready), .r_last(r_last),
        .wr_burst_done(wr_burst_done), .rd_burst_done(rd_burst_done),
        .wr_burst_count(wr_burst_count), .rd_burst_count(rd_burst_count),
        .wr_err(wr_err), .rd_err(rd_err),
        .wr_err_code(wr_err_code), .rd_err_code(rd_err_code)
`ifdef AXI_BURST_CHECKER_STALL_STATS_EN
        ,
        .wr_stall_count(wr_stall_count), .rd_stall_count(rd_stall_count)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int exp_wr = 0, exp_rd = 0;
    int wr_q[$], rd_q[$];

    typedef struct {
        logic       awv, awr;
        logic [7:0] len;
        logic       wv, wr, wl, cl, e_err;
        logic [2:0] e_code;
    } vec_t;
    vec_t tbl[10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Advance one cycle and match done pulses against the scoreboard.
    task automatic tick();
        int e;
        @(posedge clk);
        #1;
        chk("wr_done", {63'd0, wr_burst_done}, {63'd0, wr_q.size() != 0});
        if (wr_q.size() != 0) begin
            e = wr_q.pop_front();
            chk("wr_done_count", {32'd0, wr_burst_count}, 64'(e));
        end
        chk("rd_done", {63'd0, rd_burst_done}, {63'd0, rd_q.size() != 0});
        if (rd_q.size() != 0) begin
            e = rd_q.pop_front();
            chk("rd_done_count", {32'd0, rd_burst_count}, 64'(e));
        end
    endtask

    task automatic drv_w(input logic awv, input logic awr, input logic [7:0] len,
                         input logic wv, input logic wr, input logic wl, input logic cl);
        aw_valid = awv; aw_ready = awr; aw_len = len;
        w_valid = wv; w_ready = wr; w_last = wl;
        if (cl) begin exp_wr++; wr_q.push_back(exp_wr); end
        tick();
    endtask

    task automatic drv_r(input logic arv, input logic arr, input logic [7:0] len,
                         input logic rv, input logic rr, input logic rl, input logic cl);
        ar_valid = arv; ar_ready = arr; ar_len = len;
        r_valid = rv; r_ready = rr; r_last = rl;
        if (cl) begin exp_rd++; rd_q.push_back(exp_rd); end
        tick();
    endtask

    task automatic idle_inputs();
        aw_valid = 0; aw_ready = 0; aw_len = 0; w_valid = 0; w_ready = 0; w_last = 0;
        ar_valid = 0; ar_ready = 0; ar_len = 0; r_valid = 0; r_ready = 0; r_last = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        wr_q.delete(); rd_q.delete();
        exp_wr = 0; exp_rd = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic chk_err(input string nm, input logic e, input logic [2:0] c,
                           input logic ee, input logic [2:0] ec);
        chk({nm, "_err"}, {63'd0, e}, {63'd0, ee});
        chk({nm, "_code"}, {61'd0, c}, {61'd0, ec});
    endtask

    initial begin
        //            awv awr len wv wr wl cl err code
        tbl[0] = '{1'b1, 1'b0, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
        tbl[1] = '{1'b1, 1'b1, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
        tbl[2] = '{1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0};
        tbl[3] = '{1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0};
        tbl[4] = '{1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0};
        tbl[5] = '{1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0};
        tbl[6] = '{1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0};
        tbl[7] = '{1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3'd1};
        tbl[8] = '{1'b1, 1'b1, 8'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1};
        tbl[9] = '{1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd1};

        do_reset();
        chk("rst_wr_count", {32'd0, wr_burst_count}, 64'd0);
        chk("rst_rd_count", {32'd0, rd_burst_count}, 64'd0);
        chk_err("rst_wr", wr_err, wr_err_code, 1'b0, 3'd0);
        chk_err("rst_rd", rd_err, rd_err_code, 1'b0, 3'd0);
        chk("rst_dones", {62'd0, wr_burst_done, rd_burst_done}, 64'd0);

        // Normal burst, stalled handshakes, orphan beat, bypass + missing last
        for (int i = 0; i < 10; i++) begin
            drv_w(tbl[i].awv, tbl[i].awr, tbl[i].len, tbl[i].wv, tbl[i].wr, tbl[i].wl, tbl[i].cl);
            chk_err($sformatf("vec%0d_wr", i), wr_err, wr_err_code, tbl[i].e_err, tbl[i].e_code);
        end
        idle_inputs();
        tick();
        chk("vec_wr_count", {32'd0, wr_burst_count}, 64'd2);
        chk_err("vec_rd_quiet", rd_err, rd_err_code, 1'b0, 3'd0);

        // Early last on read, then a clean burst keeps the first code
        do_reset();
        drv_r(1, 1, 8'd7, 0, 0, 0, 0);
        drv_r(0, 0, 8'd0, 1, 1, 0, 0);
        drv_r(0, 0, 8'd0, 1, 1, 0, 0);
        drv_r(0, 0, 8'd0, 1, 1, 1, 1);
        chk_err("early_rd", rd_err, rd_err_code, 1'b1, 3'd2);
        chk("early_rd_count", {32'd0, rd_burst_count}, 64'd1);
        drv_r(1, 1, 8'd0, 0, 0, 0, 0);
        drv_r(0, 0, 8'd0, 1, 1, 1, 1);
        drv_r(0, 0, 8'd0, 0, 0, 0, 0);
        chk_err("early_rd_after", rd_err, rd_err_code, 1'b1, 3'd2);
        chk("early_rd_count2", {32'd0, rd_burst_count}, 64'd2);
        chk_err("early_wr_quiet", wr_err, wr_err_code, 1'b0, 3'd0);

        // Orphan write beat
        do_reset();
        drv_w(0, 0, 8'd0, 1, 1, 1, 0);
        chk_err("orphan_wr", wr_err, wr_err_code, 1'b1, 3'd1);
        chk("orphan_count0", {32'd0, wr_burst_count}, 64'd0);
        drv_w(1, 1, 8'd1, 0, 0, 0, 0);
        drv_w(0, 0, 8'd0, 1, 1, 0, 0);
        drv_w(0, 0, 8'd0, 1, 1, 1, 1);
        drv_w(0, 0, 8'd0, 0, 0, 0, 0);
        chk("orphan_count1", {32'd0, wr_burst_count}, 64'd1);

        // Overflow: fifth push into a depth-4 FIFO
        do_reset();
        for (int i = 0; i < 5; i++) drv_w(1, 1, 8'd1, 0, 0, 0, 0);
        chk_err("ovf_wr", wr_err, wr_err_code, 1'b1, 3'd4);
        for (int i = 0; i < 4; i++) begin
            drv_w(0, 0, 8'd0, 1, 1, 0, 0);
            drv_w(0, 0, 8'd0, 1, 1, 1, 1);
        end
        drv_w(0, 0, 8'd0, 0, 0, 0, 0);
        chk("ovf_count", {32'd0, wr_burst_count}, 64'd4);
        chk_err("ovf_wr_after", wr_err, wr_err_code, 1'b1, 3'd4);

        // Push and pop together while full is legal and keeps occupancy
        do_reset();
        for (int i = 0; i < 4; i++) drv_w(1, 1, 8'd0, 0, 0, 0, 0);
        drv_w(1, 1, 8'd0, 1, 1, 1, 1);
        chk_err("full_pushpop", wr_err, wr_err_code, 1'b0, 3'd0);
        for (int i = 0; i < 4; i++) drv_w(0, 0, 8'd0, 1, 1, 1, 1);
        chk_err("full_drain", wr_err, wr_err_code, 1'b0, 3'd0);
        drv_w(0, 0, 8'd0, 1, 1, 1, 0);
        chk_err("full_empty_after", wr_err, wr_err_code, 1'b1, 3'd1);
        chk("full_count", {32'd0, wr_burst_count}, 64'd5);

        // Bypass: address and closing beat together on an empty FIFO, 100 times
        do_reset();
        for (int i = 0; i < 100; i++) drv_w(1, 1, 8'd0, 1, 1, 1, 1);
        drv_w(0, 0, 8'd0, 0, 0, 0, 0);
        chk("bypass_count", {32'd0, wr_burst_count}, 64'd100);
        chk_err("bypass_wr", wr_err, wr_err_code, 1'b0, 3'd0);
        drv_r(1, 1, 8'd0, 1, 1, 1, 1);
        drv_r(0, 0, 8'd0, 0, 0, 0, 0);
        chk("bypass_rd_count", {32'd0, rd_burst_count}, 64'd1);

`ifdef AXI_BURST_CHECKER_STALL_STATS_EN
        do_reset();
        for (int i = 0; i < 6; i++) drv_r(0, 0, 8'd0, 1, 0, 0, 0);
        drv_r(0, 0, 8'd0, 0, 0, 0, 0);
        chk("rd_stall", {32'd0, rd_stall_count}, 64'd6);
        chk("wr_stall", {32'd0, wr_stall_count}, 64'd0);
        chk_err("stall_rd", rd_err, rd_err_code, 1'b0, 3'd0);
`endif

        // Asynchronous reset mid-burst discards everything
        do_reset();
        drv_w(0, 0, 8'd0, 1, 1, 1, 0);
        drv_w(1, 1, 8'd0, 1, 1, 1, 1);
        drv_w(1, 1, 8'd3, 0, 0, 0, 0);
        drv_w(0, 0, 8'd0, 1, 1, 0, 0);
        drv_w(0, 0, 8'd0, 1, 0, 0, 0);
        #2;
        rst = 1'b1;
        idle_inputs();
        #1;
        chk("arst_wr_count", {32'd0, wr_burst_count}, 64'd0);
        chk_err("arst_wr", wr_err, wr_err_code, 1'b0, 3'd0);
        @(posedge clk);
        #1;
        chk("arst_edge_count", {32'd0, wr_burst_count}, 64'd0);
        chk("arst_edge_done", {63'd0, wr_burst_done}, 64'd0);
`ifdef AXI_BURST_CHECKER_STALL_STATS_EN
        chk("arst_wr_stall", {32'd0, wr_stall_count}, 64'd0);
`endif
        wr_q.delete(); rd_q.delete();
        exp_wr = 0; exp_rd = 0;
        rst = 1'b0;
        drv_w(0, 0, 8'd0, 1, 1, 1, 0);
        drv_w(0, 0, 8'd0, 0, 0, 0, 0);
        chk_err("arst_fifo_cleared", wr_err, wr_err_code, 1'b1, 3'd1);
        chk("arst_after_count", {32'd0, wr_burst_count}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
